// File: rtl/sample_block_packer.sv
// sample_block_packer: packs i2s samples into BLOCK_BYTES-byte blocks through a ping-pong RAM.
// Latency: blk_valid rises 2 cycles after a bank fills while the drain is idle, then streams 1 byte/clock.
// Backpressure: blk_ready stalls the drain; with both banks full, new samples are dropped and overflow is set.
// Optional macro PACKER_WR_SYNC_EN: 2-flop synchronizer on wr/enable (2 extra cycles of capture latency).
module sample_block_packer #(
  parameter int WORD_WIDTH  = 8,
  parameter int BLOCK_BYTES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  enable,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [7:0]            blk_data,
  output logic                  blk_last,
  output logic                  busy,
  output logic                  overflow
);
  localparam int BPW     = WORD_WIDTH / 8;
  localparam int BPW_LOG = (BPW == 2) ? 1 : 0;
  localparam int PTR_W   = $clog2(BLOCK_BYTES);
  localparam int WORDS   = BLOCK_BYTES / BPW;
  localparam int WADDR_W = PTR_W - BPW_LOG;
  localparam logic [PTR_W:0]   BLK_END  = (PTR_W+1)'(BLOCK_BYTES);
  localparam logic [PTR_W:0]   STEP_SMP = (PTR_W+1)'(BPW);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_STREAM} drain_t;

  // ---------------- input conditioning ----------------
  logic wr_in, en_in;
`ifdef PACKER_WR_SYNC_EN
  logic [1:0] wr_sync, en_sync;
  // two-flop synchronizers for the strobe and record enable coming from another domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sync <= '0;
      en_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[0], wr};
      en_sync <= {en_sync[0], enable};
    end
  end
  assign wr_in = wr_sync[1];
  assign en_in = en_sync[1];
`else
  assign wr_in = wr;
  assign en_in = enable;
`endif

  logic wr_q, en_q;
  logic wr_rise, en_rise, en_fall;
  // previous-level registers for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      wr_q <= wr_in;
      en_q <= en_in;
    end
  end
  assign wr_rise = wr_in & ~wr_q;
  assign en_rise = en_in & ~en_q;
  assign en_fall = ~en_in & en_q;

  // ---------------- state ----------------
  logic [1:0]       bank_full;
  logic             fill_bank;
  logic [PTR_W-1:0] fill_ptr;
  logic             drop;
  logic             pad;
  drain_t           dstate, dstate_nxt;
  logic             drain_bank, drain_bank_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;

  // ---------------- fill side ----------------
  logic             other_empty_q, drop_eff, bank_eff;
  logic             cap, drop_smp, fill_we, fill_done, free_now, switch_ok, xfer;
  logic [PTR_W:0]   step, ptr_sum;
  logic [1:0]       set_vec, clr_vec;

  // A parked fill bank leaves DROP as soon as the other bank is seen empty,
  // so the first strobe after the free already lands in the freed bank.
  assign other_empty_q = ~bank_full[~fill_bank];
  assign drop_eff      = drop & ~other_empty_q;
  assign bank_eff      = (drop & other_empty_q) ? ~fill_bank : fill_bank;

  assign cap       = wr_rise & en_in & ~pad & ~drop_eff;
  assign drop_smp  = wr_rise & en_in & ~pad & drop_eff;
  assign fill_we   = cap | pad;
  assign step      = pad ? (PTR_W+1)'(1) : STEP_SMP;
  assign ptr_sum   = {1'b0, fill_ptr} + step;
  assign fill_done = fill_we & (ptr_sum == BLK_END);

  assign xfer      = blk_valid & blk_ready;
  assign free_now  = xfer & blk_last;
  // a bank freed by the drain this very cycle counts as empty for the switch
  assign switch_ok = ~bank_full[~bank_eff] | (free_now & (drain_bank == ~bank_eff));

  assign set_vec = fill_done ? (2'b01 << bank_eff) : 2'b00;
  assign clr_vec = free_now ? (2'b01 << drain_bank) : 2'b00;

  // fill pointer, bank selection, DROP and PAD control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_bank <= 1'b0;
      fill_ptr  <= '0;
      drop      <= 1'b0;
      pad       <= 1'b0;
    end else begin
      fill_bank <= bank_eff;
      if (drop & other_empty_q) drop <= 1'b0;
      if (fill_we) fill_ptr <= fill_done ? '0 : ptr_sum[PTR_W-1:0];
      if (fill_done) begin
        pad <= 1'b0;
        if (switch_ok) fill_bank <= ~bank_eff;
        else           drop      <= 1'b1;
      end else if (en_fall && !pad && fill_ptr != '0) begin
        pad <= 1'b1;
      end
    end
  end

  // bank occupancy: set by the filler, cleared by the drain after the last byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bank_full <= 2'b00;
    else      bank_full <= (bank_full | set_vec) & ~clr_vec;
  end

  // sticky overflow; a drop in the same cycle as the enable edge still counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          overflow <= 1'b0;
    else if (drop_smp) overflow <= 1'b1;
    else if (en_rise)  overflow <= 1'b0;
  end

  // ---------------- ping-pong RAM ----------------
  logic [WORD_WIDTH-1:0] mem [0:2*WORDS-1];
  logic [WORD_WIDTH-1:0] rd_word;
  logic [WADDR_W:0]      wr_addr, rd_addr;

  assign wr_addr = {bank_eff, fill_ptr[PTR_W-1:BPW_LOG]};
  assign rd_addr = {drain_bank_nxt, rd_ptr_nxt[PTR_W-1:BPW_LOG]};

  // RAM: one write port for the filler, one registered read port for the drain.
  // Padding writes a whole zero word each clock; both bytes of that word are zero anyway.
  always_ff @(posedge clk) begin
    if (fill_we) mem[wr_addr] <= pad ? '0 : din;
    rd_word <= mem[rd_addr];
  end

  // ---------------- drain side ----------------
  // drain state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dstate     <= D_IDLE;
      drain_bank <= 1'b0;
      rd_ptr     <= '0;
    end else begin
      dstate     <= dstate_nxt;
      drain_bank <= drain_bank_nxt;
      rd_ptr     <= rd_ptr_nxt;
    end
  end

  // drain next-state: oldest full bank first; read address follows the accepted byte
  always_comb begin
    dstate_nxt     = dstate;
    drain_bank_nxt = drain_bank;
    rd_ptr_nxt     = rd_ptr;
    case (dstate)
      D_IDLE: begin
        if (|bank_full) begin
          dstate_nxt     = D_LOAD;
          // with both full, the fill bank is the newer one
          drain_bank_nxt = (&bank_full) ? ~fill_bank : bank_full[1];
        end
      end
      D_LOAD: begin
        dstate_nxt = D_STREAM;
        rd_ptr_nxt = '0;
      end
      D_STREAM: begin
        if (xfer) rd_ptr_nxt = rd_ptr + PTR_W'(1);
        if (free_now) begin
          if (bank_full[~drain_bank]) begin
            dstate_nxt     = D_LOAD;
            drain_bank_nxt = ~drain_bank;
          end else begin
            dstate_nxt = D_IDLE;
          end
        end
      end
      default: dstate_nxt = D_IDLE;
    endcase
  end

  logic [7:0] rd_byte;
  // byte select within a RAM word; 16-bit samples are stored MSB byte first
  always_comb begin
    rd_byte = rd_word[7:0];
    if (BPW == 2) rd_byte = rd_ptr[0] ? rd_word[7:0] : rd_word[WORD_WIDTH-1 -: 8];
  end

  assign blk_valid = (dstate == D_STREAM);
  assign blk_last  = blk_valid & (rd_ptr == LAST_PTR);
  assign blk_data  = blk_valid ? rd_byte : 8'h00;
  assign busy      = (|bank_full) | (dstate != D_IDLE) | pad;

endmodule

// File: tb/tb_sample_block_packer.sv
// Bench for sample_block_packer: directed steps with randomized data and handshake,
// checked against a byte-stream model built from the packing rules.
module tb_sample_block_packer;
  localparam int BB = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  din8;  logic wr8, en8, rdy8;
  logic        v8, l8, busy8, ovf8;  logic [7:0] d8;
  logic [15:0] din16; logic wr16, en16, rdy16;
  logic        v16, l16, busy16, ovf16; logic [7:0] d16;

  sample_block_packer #(.WORD_WIDTH(8), .BLOCK_BYTES(BB)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .wr(wr8), .enable(en8),
    .blk_valid(v8), .blk_ready(rdy8), .blk_data(d8), .blk_last(l8),
    .busy(busy8), .overflow(ovf8));

  sample_block_packer #(.WORD_WIDTH(16), .BLOCK_BYTES(BB)) dut16 (
    .clk(clk), .rst(rst), .din(din16), .wr(wr16), .enable(en16),
    .blk_valid(v16), .blk_ready(rdy16), .blk_data(d16), .blk_last(l16),
    .busy(busy16), .overflow(ovf16));

  int checks = 0;
  int failures = 0;

  logic [8:0] obs_q[$];   // {last, data} of every accepted byte
  logic [7:0] exp_q[$];   // expected byte stream
  int   mon_sel = 0;      // 0: watch dut8, 1: watch dut16
  int   stall_err = 0;
  int   stall_seen = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_out = '0;
  int   rdy_mode = 0;     // 0: rdy_fix, 1: toggle each cycle, 2: random 75%
  logic rdy_fix = 1'b0;

  // monitor: record accepted bytes and watch output stability during stalls
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_seen++;
        if (v8 !== 1'b1 || {l8, d8} !== prev_out) stall_err++;
      end
      if (mon_sel == 0 && v8 && rdy8)   obs_q.push_back({l8, d8});
      if (mon_sel == 1 && v16 && rdy16) obs_q.push_back({l16, d16});
      prev_stall = v8 && !rdy8;
      prev_out   = {l8, d8};
    end
  end

  // consumer ready pattern for dut8
  initial begin
    rdy8 = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       rdy8 = ~rdy8;
        2:       rdy8 = ($urandom_range(0, 3) != 0);
        default: rdy8 = rdy_fix;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input int gap);
    @(posedge clk); #1; din8 = d; wr8 = 1'b1;
    @(posedge clk); #1; wr8 = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [15:0] d);
    @(posedge clk); #1; din16 = d; wr16 = 1'b1;
    @(posedge clk); #1; wr16 = 1'b0;
  endtask

  task automatic wait_idle8(input string tag, input int maxc);
    int n = 0;
    while (busy8 !== 1'b0 && n < maxc) begin @(posedge clk); #1; n++; end
    chk({tag, "_idle"}, 32'(busy8), 0);
  endtask

  // zero bytes the packer appends when recording stops mid-block
  task automatic model_pad();
    while (exp_q.size() % BB != 0) exp_q.push_back(8'h00);
  endtask

  // every byte in order, blk_last exactly on each block's final byte
  task automatic check_stream(input string tag);
    int bad = 0;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      logic [8:0] e;
      e = {((i % BB) == BB - 1), exp_q[i]};
      if (obs_q[i] !== e) bad++;
    end
    chk({tag, "_bytes"}, bad, 0);
  endtask

  task automatic clear_model();
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    rst = 1'b0;
    din8 = '0; wr8 = 1'b0; en8 = 1'b0;
    din16 = '0; wr16 = 1'b0; en16 = 1'b0; rdy16 = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v8), 0);
    chk("rst_last", 32'(l8), 0);
    chk("rst_data", 32'(d8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_ovf", 32'(ovf8), 0);
    rst = 1'b1;
    en8 = 1'b1; en16 = 1'b1;

    // counting pattern, consumer always ready
    rdy_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < BB; k++) begin
      b = k[7:0];
      send8(b, 0);
      exp_q.push_back(b);
    end
    n = 0;
    while (v8 !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    chk("full_to_valid_le2", 32'(n <= 2), 1);
    wait_idle8("count", 2000);
    check_stream("count");
    clear_model();

    // 16-bit samples stored MSB first
    mon_sel = 1; rdy16 = 1'b1;
    for (int k = 0; k < BB / 2; k++) begin
      send16(16'hA1B2);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
    end
    n = 0;
    while (busy16 !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("w16_idle", 32'(busy16), 0);
    check_stream("w16");
    clear_model();
    mon_sel = 0;

    // recording stops after 100 samples: zero padding fills the block
    for (int k = 0; k < 100; k++) begin
      b = k[7:0];
      send8(b, 0);
      exp_q.push_back(b);
    end
    en8 = 1'b0;
    model_pad();
    repeat (2) @(posedge clk);
    #1;
    chk("pad_busy", 32'(busy8), 1);
    wait_idle8("pad", 2000);
    check_stream("pad");
    clear_model();
    en8 = 1'b1;

    // ready toggling: stalls must hold the byte, nothing lost or repeated
    stall_err = 0; stall_seen = 0;
    rdy_mode = 1;
    for (int k = 0; k < BB; k++) begin
      b = 8'($urandom_range(0, 255));
      send8(b, 0);
      exp_q.push_back(b);
    end
    wait_idle8("toggle", 3000);
    check_stream("toggle");
    chk("toggle_stall_seen", 32'(stall_seen > 0), 1);
    chk("toggle_stall_stable", stall_err, 0);
    clear_model();

    // random data, random gaps, random ready, ends with a padded block
    rdy_mode = 2;
    for (int k = 0; k < 1100; k++) begin
      b = 8'($urandom_range(0, 255));
      send8(b, $urandom_range(0, 3));
      exp_q.push_back(b);
    end
    en8 = 1'b0;
    model_pad();
    repeat (2) @(posedge clk);
    #1;
    wait_idle8("rand", 4000);
    check_stream("rand");
    clear_model();
    rdy_mode = 0; rdy_fix = 1'b0;

    // consumer stalled: two blocks are held and the third block's samples are lost
    en8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_ovf_before", 32'(ovf8), 0);
    for (int k = 0; k < 3 * BB; k++) begin
      b = k[7:0];
      send8(b, 0);
      if (k < 2 * BB) exp_q.push_back(b);
    end
    chk("drop_ovf_set", 32'(ovf8), 1);
    chk("drop_held_valid", 32'(v8), 1);
    chk("drop_nothing_out", obs_q.size(), 0);
    rdy_fix = 1'b1;
    wait_idle8("drop", 4000);
    repeat (20) @(posedge clk);
    #1;
    check_stream("drop");
    chk("drop_ovf_sticky", 32'(ovf8), 1);
    en8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_ovf_clear", 32'(ovf8), 0);
    clear_model();

    // reset in the middle of a drain
    rdy_fix = 1'b0;
    for (int k = 0; k < BB; k++) send8(8'($urandom_range(0, 255)), 0);
    rdy_fix = 1'b1;
    n = 0;
    while (obs_q.size() < 200 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("rstmid_reach", 32'(obs_q.size() >= 200), 1);
    chk("rstmid_valid_before", 32'(v8), 1);
    rst = 1'b0;
    #1;
    chk("rstmid_valid", 32'(v8), 0);
    chk("rstmid_last", 32'(l8), 0);
    chk("rstmid_data", 32'(d8), 0);
    chk("rstmid_busy", 32'(busy8), 0);
    chk("rstmid_ovf", 32'(ovf8), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    for (int k = 0; k < BB; k++) begin
      b = 8'($urandom_range(0, 255));
      send8(b, 0);
      exp_q.push_back(b);
    end
    wait_idle8("after_rst", 2000);
    check_stream("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_block_packer.md
SAMPLE_BLOCK_PACKER -- requirements
Module: sample_block_packer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, sample width in bits; legal values are 8 and 16.
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, bytes per output block; power of two, at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port din, input, WORD_WIDTH bits: sample from the i2s receiver.
REQ-006 SHALL have port wr, input, 1 bit: sample strobe level (word-select); a rising edge means din is valid.
REQ-007 SHALL have port enable, input, 1 bit: record enable.
REQ-008 SHALL have port blk_valid, output, 1 bit: blk_data holds a valid byte.
REQ-009 SHALL have port blk_ready, input, 1 bit: the consumer accepts the byte.
REQ-010 SHALL have port blk_data, output, 8 bits: block byte stream.
REQ-011 SHALL have port blk_last, output, 1 bit: final byte of a block.
REQ-012 SHALL have port busy, output, 1 bit: a block is pending, draining or padding.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag meaning a sample was dropped.

Function
REQ-014 SHALL hold two banks of BLOCK_BYTES bytes (ping-pong); at any time one bank is the fill bank and each bank is EMPTY, FILLING or FULL.
REQ-015 SHALL capture din into the fill bank at fill_ptr on each wr rising edge detected while enable=1, then advance fill_ptr by WORD_WIDTH/8; 16-bit samples are stored MSB byte first.
REQ-016 SHALL mark the fill bank FULL when fill_ptr reaches BLOCK_BYTES, then wrap fill_ptr to 0 and switch to the other bank if that bank is EMPTY.
REQ-017 SHALL, when the other bank is not EMPTY at switch time, enter a DROP condition: samples are discarded and overflow is set until that bank frees.
REQ-018 SHALL resume capture into the freed bank at the first wr edge after the bank frees.
REQ-019 SHALL, on a falling edge of enable with 0 < fill_ptr < BLOCK_BYTES, enter PAD: write 0x00 at one byte per clock until the bank is full, then apply REQ-016; wr edges during PAD are ignored.
REQ-020 SHALL drain with a state machine IDLE -> LOAD -> STREAM -> IDLE:
  - IDLE -> LOAD when any bank is FULL; the oldest bank is taken first.
  - LOAD lasts 1 cycle (RAM read).
  - STREAM presents bytes 0..BLOCK_BYTES-1 in order.
REQ-021 SHALL assert blk_valid no later than 2 cycles after a bank becomes FULL while the drain is IDLE.
REQ-022 SHALL transfer a byte only on a cycle where blk_valid=1 and blk_ready=1; blk_data and blk_last SHALL stay stable while blk_valid=1 and blk_ready=0.
REQ-023 SHALL sustain one byte per clock while blk_ready is held at 1.
REQ-024 SHALL assert blk_last exactly with byte BLOCK_BYTES-1; after that transfer the bank becomes EMPTY, and blk_valid drops unless the other bank is FULL, in which case it returns through LOAD.
REQ-025 SHALL allow a fill write and a drain read to different banks in the same cycle without stall.
REQ-026 SHALL, when a bank frees in the same cycle the fill bank fills, perform the switch with no drop and no overflow.
REQ-027 SHALL clear overflow only on reset or on a rising edge of enable.
REQ-028 SHALL drive busy = (any bank FULL) OR (drain not IDLE) OR PAD.

Reset
REQ-029 SHALL, while rst=0, force blk_valid=0, blk_last=0, blk_data=0, busy=0, overflow=0, both banks EMPTY, fill bank 0, fill_ptr 0, drain IDLE, and edge detectors to 0.
REQ-030 SHALL discard any block in flight when reset is asserted mid-block, and resume normal operation on the first clock after rst=1; RAM contents need not be cleared.

Configuration
REQ-031 SHALL, with macro PACKER_WR_SYNC_EN defined, pass wr and enable through a 2-flop synchronizer before edge detection, adding 2 cycles of capture latency.
REQ-032 SHALL, without PACKER_WR_SYNC_EN, edge-detect wr and enable directly from a single register stage.

Verification
REQ-033 SHALL cover: 512 wr edges with enable=1 and din=n mod 256, blk_ready=1 -> 512 bytes 0x00..0xFF,0x00..0xFF, blk_last on byte 511 only, then busy=0.
REQ-034 SHALL cover: WORD_WIDTH=16, 256 samples of 0xA1B2 -> bytes alternate A1,B2; blk_last on byte 511.
REQ-035 SHALL cover: blk_ready=0 while 1536 samples arrive -> 2 blocks held, overflow=1, 512 samples dropped; then blk_ready=1 -> exactly 1024 bytes output.
REQ-036 SHALL cover: 100 samples, then enable falls -> block of bytes 0..99 followed by 412 bytes of 0x00, blk_last on byte 511.
REQ-037 SHALL cover: blk_ready toggling every cycle -> blk_data constant while stalled, and no byte lost or duplicated across 512 bytes.
REQ-038 SHALL cover: rst=0 asserted at byte 200 of a drain -> all outputs 0 at once; after release a new 512-sample run drains correctly.
